// File: rtl/rectcalc_pkg.sv
// Shared constants for the polar-to-rectangular CORDIC: atan ROM,
// prescale gain, angle landmarks in Q9.10 degrees and FSM states.
package rectcalc_pkg;

    localparam int KINV    = 39797;
    localparam int ANG_90  = 92160;
    localparam int ANG_180 = 184320;

    typedef enum logic [1:0] {
        IDLE,
        PRESCALE,
        ITER,
        FINISH
    } state_t;

    // atan(2^-i) in Q9.10 degrees
    function automatic int atan_rom(input int i);
        case (i)
            0:       return 46080;
            1:       return 27203;
            2:       return 14373;
            3:       return 7296;
            4:       return 3662;
            5:       return 1833;
            6:       return 917;
            7:       return 458;
            8:       return 229;
            9:       return 115;
            10:      return 57;
            11:      return 29;
            12:      return 14;
            13:      return 7;
            14:      return 4;
            15:      return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/rectcalc_pol2rec_all.sv
// Iterative CORDIC core in rotation mode: one micro-rotation per cycle,
// with its own iteration counter and x/y/z state.
module pol2rec_all
    import rectcalc_pkg::*;
#(
    parameter int ROMSIZE     = 16,
    parameter int COUNTERSIZE = 5,
    parameter int XW          = 23,
    parameter int ZW          = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic signed [XW-1:0] x0,
    input  logic signed [ZW-1:0] z0,
    output logic signed [XW-1:0] xo,
    output logic signed [XW-1:0] yo,
    output logic                 last
);

    logic signed [XW-1:0]    xr;
    logic signed [XW-1:0]    yr;
    logic signed [ZW-1:0]    zr;
    logic [COUNTERSIZE-1:0]  cnt;
    logic signed [XW-1:0]    xs;
    logic signed [XW-1:0]    ys;
    logic signed [ZW-1:0]    at;

    assign xs   = xr >>> cnt;
    assign ys   = yr >>> cnt;
    assign at   = ZW'(atan_rom(int'(cnt)));
    assign last = (cnt == COUNTERSIZE'(ROMSIZE - 1));
    assign xo   = xr;
    assign yo   = yr;

    always_ff @(posedge clock) begin
        if (reset) begin
            xr  <= '0;
            yr  <= '0;
            zr  <= '0;
            cnt <= '0;
        end else if (load) begin
            xr  <= x0;
            yr  <= '0;
            zr  <= z0;
            cnt <= '0;
        end else if (run) begin
            if (!zr[ZW-1]) begin
                xr <= xr - ys;
                yr <= yr + xs;
                zr <= zr - at;
            end else begin
                xr <= xr + ys;
                yr <= yr - xs;
                zr <= zr + at;
            end
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rectcalc.sv
// Polar-to-rectangular converter: quadrant fold, gain prescale, CORDIC
// iterations, then rounding/saturation behind a start/busy/done handshake.
module rectcalc
    import rectcalc_pkg::*;
#(
    parameter int ROMSIZE     = 16,
    parameter int COUNTERSIZE = 5,
    parameter int INSIZE      = 13,
    parameter int OUTSIZE     = 19
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [INSIZE-2:0]         mod,
    input  logic signed [OUTSIZE-1:0] angle,
    output logic signed [INSIZE-1:0]  x,
    output logic signed [INSIZE-1:0]  y
);

    localparam int XW = INSIZE + 2 + 8;
    localparam int ZW = OUTSIZE + 1;
    localparam int PW = INSIZE - 1 + 16;

    localparam logic signed [ZW-1:0]   A90  = ZW'(ANG_90);
    localparam logic signed [ZW-1:0]   A180 = ZW'(ANG_180);
    localparam logic [15:0]            KV   = 16'(KINV);
    localparam logic signed [XW-8:0]   LIM  = (XW-7)'(2**(INSIZE-1) - 1);

    state_t                    state;
    logic [INSIZE-2:0]         modr;
    logic signed [OUTSIZE-1:0] angr;
    logic                      neg;

    logic signed [ZW-1:0]      ang_e;
    logic signed [ZW-1:0]      z0;
    logic                      fold_neg;
    logic [PW-1:0]             prod;
    logic [PW-1:0]             prnd;
    logic signed [XW-1:0]      x0;
    logic signed [XW-1:0]      xc;
    logic signed [XW-1:0]      yc;
    logic                      last;
    logic                      load;
    logic                      run;

    assign ang_e = {angr[OUTSIZE-1], angr};
    assign prod  = PW'(modr) * PW'(KV);
    assign prnd  = prod + PW'(128);
    assign x0    = XW'(prnd[PW-1:8]);
    assign load  = (state == PRESCALE);
    assign run   = (state == ITER);

    // Bring the angle into the CORDIC convergence range; the half-turn
    // shift is undone by negating both outputs at the end.
    always_comb begin
        z0       = ang_e;
        fold_neg = 1'b0;
        if (ang_e > A90) begin
            z0       = ang_e - A180;
            fold_neg = 1'b1;
        end else if (ang_e < -A90) begin
            z0       = ang_e + A180;
            fold_neg = 1'b1;
        end
    end

    function automatic logic signed [INSIZE-1:0] finish_val(
        input logic signed [XW-1:0] v,
        input logic                 n
    );
        logic signed [XW-1:0] r;
        logic signed [XW-8:0] t;
        r = v + XW'(128);
        t = {r[XW-1], r[XW-1:8]};
        if (n)
            t = -t;
        if (t > LIM)
            return LIM[INSIZE-1:0];
        else if (t < -LIM)
            return (-LIM) & {(XW-7){1'b1}} ? INSIZE'(-LIM) : INSIZE'(-LIM);
        else
            return t[INSIZE-1:0];
    endfunction

    pol2rec_all #(
        .ROMSIZE     (ROMSIZE),
        .COUNTERSIZE (COUNTERSIZE),
        .XW          (XW),
        .ZW          (ZW)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .run   (run),
        .x0    (x0),
        .z0    (z0),
        .xo    (xc),
        .yo    (yc),
        .last  (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
            modr  <= '0;
            angr  <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        modr  <= mod;
                        angr  <= angle;
                        busy  <= 1'b1;
                        state <= PRESCALE;
                    end
                end
                PRESCALE: begin
                    neg   <= fold_neg;
                    state <= ITER;
                end
                ITER: begin
                    if (last)
                        state <= FINISH;
                end
                FINISH: begin
                    x     <= finish_val(xc, neg);
                    y     <= finish_val(yc, neg);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rectcalc.sv
// Directed bench for rectcalc: cardinal/diagonal points, angle sweep against
// a real-valued model, handshake timing, reset abort and zero magnitude.
module tb_rectcalc;

    localparam real PI = 3.14159265358979;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic [11:0]        mod = '0;
    logic signed [18:0] angle = '0;
    logic signed [12:0] x;
    logic signed [12:0] y;

    int nvec = 0;
    int nerr = 0;

    rectcalc dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .mod   (mod),
        .angle (angle),
        .x     (x),
        .y     (y)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input real exp);
        real d;
        d = obs - exp;
        if (d < 0.0)
            d = -d;
        nvec++;
        assert ((d <= 2.0) === 1'b1) else begin
            nerr++;
            $error("FAIL %s: got %0d, want %0.2f +-2", tag, obs, exp);
        end
    endtask

    function automatic real mx(input int m, input int a);
        return m * $cos(a / 1024.0 * PI / 180.0);
    endfunction

    function automatic real my(input int m, input int a);
        return m * $sin(a / 1024.0 * PI / 180.0);
    endfunction

    // Start one conversion; lat counts edges from the accepting edge to done.
    task automatic run_conv(input int m, input int a, output int xo,
                            output int yo, output int lat, output int bcnt);
        mod   = 12'(m);
        angle = 19'(a);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int n = 0; n < 40; n++) begin
            if (busy)
                bcnt++;
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clock);
            #1;
        end
        xo = int'(x);
        yo = int'(y);
    endtask

    initial begin
        int xo, yo, lat, bcnt, ndone, x2, y2;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_conv(1000, 0, xo, yo, lat, bcnt);
        chk_near("c0_x", xo, 1000.0);
        chk_near("c0_y", yo, 0.0);
        chk("c0_lat", lat, 18);
        chk("c0_busy", bcnt, 18);

        run_conv(1000, 92160, xo, yo, lat, bcnt);
        chk_near("c90_x", xo, 0.0);
        chk_near("c90_y", yo, 1000.0);
        chk("c90_lat", lat, 18);

        run_conv(1000, -184320, xo, yo, lat, bcnt);
        chk_near("c180_x", xo, -1000.0);
        chk_near("c180_y", yo, 0.0);
        chk("c180_lat", lat, 18);

        run_conv(4095, 46080, xo, yo, lat, bcnt);
        chk_near("d45_x", xo, 2895.61);
        chk_near("d45_y", yo, 2895.61);

        run_conv(4095, -138240, xo, yo, lat, bcnt);
        chk_near("dm135_x", xo, -2895.61);
        chk_near("dm135_y", yo, -2895.61);

        for (int a = -262144; a <= 262143; a += 1024) begin
            run_conv(2000, a, xo, yo, lat, bcnt);
            chk_near($sformatf("sw_x_%0d", a), xo, mx(2000, a));
            chk_near($sformatf("sw_y_%0d", a), yo, my(2000, a));
        end

        run_conv(2000, 204800, xo, yo, lat, bcnt);
        run_conv(2000, -163840, x2, y2, lat, bcnt);
        chk("alias_x", xo, x2);
        chk("alias_y", yo, y2);
        chk_near("alias_ref", xo, mx(2000, -163840));

        // Only the first of three start pulses may be taken.
        ndone = 0;
        bcnt  = 0;
        xo    = 0;
        yo    = 0;
        for (int c = 0; c < 30; c++) begin
            start = (c == 3 || c == 5 || c == 10);
            mod   = (c == 3) ? 12'd1000 : 12'd3000;
            angle = (c == 3) ? 19'sd0 : 19'sd92160;
            @(posedge clock);
            #1;
            if (busy)
                bcnt++;
            if (done) begin
                ndone++;
                xo = int'(x);
                yo = int'(y);
            end
        end
        start = 1'b0;
        chk("hs_done", ndone, 1);
        chk("hs_busy", bcnt, 18);
        chk_near("hs_x", xo, 1000.0);
        chk_near("hs_y", yo, 0.0);

        // start held high across done: next conversion starts at once.
        mod   = 12'd1000;
        angle = 19'sd0;
        start = 1'b1;
        @(posedge clock);
        #1;
        mod   = 12'd2000;
        angle = 19'sd92160;
        lat   = -1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("b2b_lat1", lat, 18);
        chk_near("b2b_x1", int'(x), 1000.0);
        chk_near("b2b_y1", int'(y), 0.0);
        chk("b2b_idle", int'(busy), 0);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("b2b_lat2", lat, 18);
        chk_near("b2b_x2", int'(x), 0.0);
        chk_near("b2b_y2", int'(y), 2000.0);

        // Abort mid-conversion.
        mod   = 12'd1500;
        angle = 19'sd46080;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        chk("ab_x", int'(x), 0);
        chk("ab_y", int'(y), 0);
        ndone = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (done)
                ndone++;
        end
        chk("ab_nodone", ndone, 0);
        run_conv(1000, 92160, xo, yo, lat, bcnt);
        chk_near("ab_x2", xo, 0.0);
        chk_near("ab_y2", yo, 1000.0);
        chk("ab_lat", lat, 18);

        run_conv(0, 12345, xo, yo, lat, bcnt);
        chk("z_x", xo, 0);
        chk("z_y", yo, 0);
        chk("z_lat", lat, 18);
        ndone = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (done)
                ndone++;
        end
        chk("z_once", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
